// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch initiator for the pipelined RISC-V core. It keeps the
// fetch PC and issues one read at a time to instruction memory. Returned
// words are captured into the IF/ID register. A one-entry skid buffer parks
// a word that arrives while decode is stalled. Branch/jump redirects
// restart the stream, and any response still in flight for the old stream
// is thrown away.
//
// Parameters
//   RESET_PC  PC loaded on reset
//   PC_STEP   byte increment between sequential fetches
//   BUBBLE    instruction value presented while if_valid_o is low
//
// Ports
//   clk_i             clock, all state updates on the rising edge
//   rst_ni            synchronous active-low reset
//   redirect_valid_i  taken branch/jump; load redirect_pc_i this cycle
//   redirect_pc_i     redirect target; bits [1:0] are ignored
//   id_ready_i        decode accepts the IF/ID entry this cycle
//   imem_req_o        one-cycle read request strobe
//   imem_addr_o       byte address of the request
//   imem_rvalid_i     read data valid, at least one cycle after the request
//   imem_rdata_i      returned instruction word
//   if_valid_o        IF/ID register holds a live instruction
//   if_pc_o           PC of if_instr_o
//   if_instr_o        fetched instruction, BUBBLE when not valid
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_ready_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        skidValid_q, skidValid_d;
    logic [31:0] skidPc_q, skidPc_d;
    logic [31:0] skidInstr_q, skidInstr_d;
    logic        ifValid_q, ifValid_d;
    logic [31:0] ifPc_q, ifPc_d;
    logic [31:0] ifInstr_q, ifInstr_d;

    logic        consume;
    logic        outFree;

    // Decode takes the IF/ID entry whenever it is live and decode is ready.
    // The register can take a fresh word if it is empty or being emptied now.
    assign consume = ifValid_q && id_ready_i;
    assign outFree = !ifValid_q || consume;

    // Next-state logic for the fetch FSM, PC, IF/ID register and skid buffer.
    // The normal per-state behaviour is worked out first; a redirect is then
    // applied on top so that it wins over everything except reset. A consume
    // empties the IF/ID register unless something refills it the same cycle.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        skidValid_d = skidValid_q;
        skidPc_d    = skidPc_q;
        skidInstr_d = skidInstr_q;
        ifValid_d   = ifValid_q;
        ifPc_d      = ifPc_q;
        ifInstr_d   = ifInstr_q;

        if (consume) begin
            ifValid_d = 1'b0;
            ifInstr_d = BUBBLE;
        end

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    if (drop_q) begin
                        // Response belongs to a stream that was redirected away.
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (outFree) begin
                        ifValid_d = 1'b1;
                        ifPc_d    = pc_q;
                        ifInstr_d = imem_rdata_i;
                        pc_d      = pc_q + PC_STEP;
                        state_d   = S_REQ;
                    end else begin
                        // Decode is stalled: park the word and stop fetching.
                        skidValid_d = 1'b1;
                        skidPc_d    = pc_q;
                        skidInstr_d = imem_rdata_i;
                        pc_d        = pc_q + PC_STEP;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // The IF/ID register is always occupied here, so id_ready_i
                // alone means the current entry leaves and the skid moves up.
                if (id_ready_i) begin
                    ifValid_d   = 1'b1;
                    ifPc_d      = skidPc_q;
                    ifInstr_d   = skidInstr_q;
                    skidValid_d = 1'b0;
                    state_d     = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (redirect_valid_i) begin
            pc_d        = redirect_pc_i & ~32'h3;
            ifValid_d   = 1'b0;
            ifPc_d      = ifPc_q;
            ifInstr_d   = BUBBLE;
            skidValid_d = 1'b0;
            case (state_q)
                S_REQ: begin
                    // The old request is already on the bus; its answer must be dropped.
                    drop_d  = 1'b1;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                default: begin
                    drop_d  = 1'b0;
                    state_d = S_REQ;
                end
            endcase
        end
    end

    // State register. Reset is synchronous and overrides every other input,
    // including a redirect or a response arriving in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            skidValid_q <= 1'b0;
            skidPc_q    <= 32'h0;
            skidInstr_q <= BUBBLE;
            ifValid_q   <= 1'b0;
            ifPc_q      <= 32'h0;
            ifInstr_q   <= BUBBLE;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            skidValid_q <= skidValid_d;
            skidPc_q    <= skidPc_d;
            skidInstr_q <= skidInstr_d;
            ifValid_q   <= ifValid_d;
            ifPc_q      <= ifPc_d;
            ifInstr_q   <= ifInstr_d;
        end
    end

    // The request strobe and address come straight from the FSM state and PC.
    assign imem_req_o  = (state_q == S_REQ);
    assign imem_addr_o = pc_q;

    assign if_valid_o  = ifValid_q;
    assign if_pc_o     = ifPc_q;
    assign if_instr_o  = ifInstr_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Bench for if_fetch_unit. An instruction memory model answers each request
// after a programmable latency with a word derived from its address, so any
// word that shows up on the IF/ID side can be traced back to its PC. Directed
// scenarios cover reset, free-running fetch, decode stalls, redirects and
// reset during an outstanding read. A random phase compares everything
// decode accepts against the expected program-order PC stream.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] BUBBLE   = 32'h0000_0000;

    logic        clk;
    logic        rstN;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        idReady;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        ifValid;
    logic [31:0] ifPc;
    logic [31:0] ifInstr;

    int          nChecks = 0;
    int          nFails  = 0;

    int          latency = 1;
    bit          autoMem = 1'b1;
    logic [31:0] memKey  = 32'h0;
    logic [31:0] reqLog[$];
    bit          pending;
    int          cnt;
    logic [31:0] pendAddr;

    if_fetch_unit #(
        .RESET_PC(RESET_PC),
        .PC_STEP (32'd4),
        .BUBBLE  (BUBBLE)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rstN),
        .redirect_valid_i(redirectValid),
        .redirect_pc_i   (redirectPc),
        .id_ready_i      (idReady),
        .imem_req_o      (imemReq),
        .imem_addr_o     (imemAddr),
        .imem_rvalid_i   (imemRvalid),
        .imem_rdata_i    (imemRdata),
        .if_valid_o      (ifValid),
        .if_pc_o         (ifPc),
        .if_instr_o      (ifInstr)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: every address maps to a distinct scrambled word.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ memKey;
    endfunction

    // Instruction memory model. Requests are logged at every falling edge;
    // in automatic mode each request is answered with a one-cycle rvalid
    // pulse 'latency' cycles after the request cycle.
    initial begin
        imemRvalid = 1'b0;
        imemRdata  = 32'h0;
        pending    = 1'b0;
        cnt        = 0;
        pendAddr   = 32'h0;
        forever begin
            @(negedge clk);
            if (imemReq) reqLog.push_back(imemAddr);
            if (!rstN) pending = 1'b0;
            if (autoMem) begin
                imemRvalid = 1'b0;
                if (pending) begin
                    cnt = cnt - 1;
                    if (cnt <= 0) begin
                        imemRvalid = 1'b1;
                        imemRdata  = memWord(pendAddr);
                        pending    = 1'b0;
                    end
                end
                if (imemReq && rstN) begin
                    pending  = 1'b1;
                    pendAddr = imemAddr;
                    cnt      = latency;
                end
            end
        end
    end

    // Hard stop in case something wedges the stimulus.
    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not complete, failures so far %0d", nFails);
        $fatal(1, "[TB] timeout");
    end

    // Holds reset for three cycles and releases it just after a falling edge.
    task automatic doReset;
        rstN          = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = 32'h0;
        idReady       = 1'b1;
        autoMem       = 1'b1;
        latency       = 1;
        repeat (3) @(negedge clk);
        #1;
        reqLog.delete();
        rstN = 1'b1;
    endtask

    // Reset state, and reset winning over a simultaneous redirect.
    task automatic test_reset;
        rstN          = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = 32'h0;
        idReady       = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        nChecks++; if (ifValid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %b expected 0", ifValid); end
        nChecks++; if (ifPc !== 32'h0) begin nFails++; $display("[TB] FAIL reset_pc: got %h expected 00000000", ifPc); end
        nChecks++; if (ifInstr !== BUBBLE) begin nFails++; $display("[TB] FAIL reset_instr: got %h expected %h", ifInstr, BUBBLE); end
        nChecks++; if (imemReq !== 1'b0) begin nFails++; $display("[TB] FAIL reset_req: got %b expected 0", imemReq); end
        redirectValid = 1'b1;
        redirectPc    = 32'h0000_0100;
        @(negedge clk);
        #1;
        redirectValid = 1'b0;
        nChecks++; if (imemAddr !== RESET_PC) begin nFails++; $display("[TB] FAIL reset_over_redirect: got %h expected %h", imemAddr, RESET_PC); end
        nChecks++; if (imemReq !== 1'b0) begin nFails++; $display("[TB] FAIL reset_over_redirect_req: got %b expected 0", imemReq); end
    endtask

    // Latency 1, decode always ready: requests every other cycle starting at
    // the first cycle after IDLE, first instruction visible in cycle 3.
    task automatic test_free_run;
        logic        expValid;
        logic        expReq;
        logic [31:0] expPc;
        logic [31:0] expAddr;
        doReset();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            #1;
            expValid = (c >= 3) && (c % 2 == 1);
            expReq   = (c % 2 == 1);
            expPc    = 32'((c - 3) * 2);
            expAddr  = 32'((c - 1) * 2);
            nChecks++; if (ifValid !== expValid) begin nFails++; $display("[TB] FAIL free_valid c%0d: got %b expected %b", c, ifValid, expValid); end
            if (expValid) begin
                nChecks++; if (ifPc !== expPc) begin nFails++; $display("[TB] FAIL free_pc c%0d: got %h expected %h", c, ifPc, expPc); end
                nChecks++; if (ifInstr !== memWord(expPc)) begin nFails++; $display("[TB] FAIL free_instr c%0d: got %h expected %h", c, ifInstr, memWord(expPc)); end
            end else begin
                nChecks++; if (ifInstr !== BUBBLE) begin nFails++; $display("[TB] FAIL free_bubble c%0d: got %h expected %h", c, ifInstr, BUBBLE); end
            end
            nChecks++; if (imemReq !== expReq) begin nFails++; $display("[TB] FAIL free_req c%0d: got %b expected %b", c, imemReq, expReq); end
            if (expReq) begin
                nChecks++; if (imemAddr !== expAddr) begin nFails++; $display("[TB] FAIL free_addr c%0d: got %h expected %h", c, imemAddr, expAddr); end
            end
        end
    endtask

    // Decode stalls for 5 cycles once PC 4 is presented; the word for PC 8
    // waits in the skid buffer and no new request is made until release.
    task automatic test_stall;
        bit found = 1'b0;
        doReset();
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #1;
            if (ifValid && ifPc == 32'h4) found = 1'b1;
        end
        nChecks++; if (!found) begin nFails++; $display("[TB] FAIL stall_reach_pc4: got no pc 4 expected pc 4 within 20 cycles"); end
        if (found) begin
            idReady = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                #1;
                nChecks++; if (ifValid !== 1'b1) begin nFails++; $display("[TB] FAIL stall_valid k%0d: got %b expected 1", k, ifValid); end
                nChecks++; if (ifPc !== 32'h4) begin nFails++; $display("[TB] FAIL stall_pc k%0d: got %h expected 00000004", k, ifPc); end
                nChecks++; if (ifInstr !== memWord(32'h4)) begin nFails++; $display("[TB] FAIL stall_instr k%0d: got %h expected %h", k, ifInstr, memWord(32'h4)); end
                nChecks++; if (imemReq !== 1'b0) begin nFails++; $display("[TB] FAIL stall_noreq k%0d: got %b expected 0", k, imemReq); end
            end
            idReady = 1'b1;
            @(negedge clk);
            #1;
            nChecks++; if (ifValid !== 1'b1) begin nFails++; $display("[TB] FAIL release_valid: got %b expected 1", ifValid); end
            nChecks++; if (ifPc !== 32'h8) begin nFails++; $display("[TB] FAIL release_pc: got %h expected 00000008", ifPc); end
            nChecks++; if (ifInstr !== memWord(32'h8)) begin nFails++; $display("[TB] FAIL release_instr: got %h expected %h", ifInstr, memWord(32'h8)); end
            nChecks++; if (imemReq !== 1'b1) begin nFails++; $display("[TB] FAIL release_req: got %b expected 1", imemReq); end
            nChecks++; if (imemAddr !== 32'hC) begin nFails++; $display("[TB] FAIL release_addr: got %h expected 0000000c", imemAddr); end
        end
    endtask

    // Latency 3, redirect to 0x40 the cycle after the request for 8 goes
    // out: the late answer for 8 must never reach decode.
    task automatic test_redirect_stale;
        bit found   = 1'b0;
        bit sawPc8  = 1'b0;
        bit seen40  = 1'b0;
        int idx;
        doReset();
        latency = 3;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            #1;
            if (imemReq && imemAddr == 32'h8) found = 1'b1;
        end
        nChecks++; if (!found) begin nFails++; $display("[TB] FAIL stale_reach_req8: got no request expected request for 8"); end
        if (found) begin
            @(negedge clk);
            #1;
            redirectValid = 1'b1;
            redirectPc    = 32'h0000_0040;
            idx           = reqLog.size();
            @(negedge clk);
            #1;
            redirectValid = 1'b0;
            nChecks++; if (ifValid !== 1'b0) begin nFails++; $display("[TB] FAIL stale_cleared: got %b expected 0", ifValid); end
            for (int i = 0; i < 30 && !seen40; i++) begin
                if (ifValid && ifPc == 32'h8) sawPc8 = 1'b1;
                if (ifValid && ifPc == 32'h40) begin
                    seen40 = 1'b1;
                    nChecks++; if (ifInstr !== memWord(32'h40)) begin nFails++; $display("[TB] FAIL stale_instr40: got %h expected %h", ifInstr, memWord(32'h40)); end
                end
                if (!seen40) begin
                    @(negedge clk);
                    #1;
                end
            end
            nChecks++; if (sawPc8) begin nFails++; $display("[TB] FAIL stale_pc8_seen: got pc 8 on IF/ID expected never"); end
            nChecks++; if (!seen40) begin nFails++; $display("[TB] FAIL stale_pc40: got none expected pc 00000040"); end
            nChecks++;
            if (reqLog.size() <= idx) begin nFails++; $display("[TB] FAIL stale_next_addr: got no request expected 00000040"); end
            else if (reqLog[idx] !== 32'h40) begin nFails++; $display("[TB] FAIL stale_next_addr: got %h expected 00000040", reqLog[idx]); end
        end
    endtask

    // Redirect to an unaligned target in the same cycle a response arrives.
    task automatic test_redirect_rvalid;
        bit found = 1'b0;
        doReset();
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #1;
            if (imemRvalid && reqLog.size() >= 2) found = 1'b1;
        end
        nChecks++; if (!found) begin nFails++; $display("[TB] FAIL rv_reach: got no response expected response for 4"); end
        if (found) begin
            redirectValid = 1'b1;
            redirectPc    = 32'h0000_002E;
            @(negedge clk);
            #1;
            redirectValid = 1'b0;
            nChecks++; if (ifValid !== 1'b0) begin nFails++; $display("[TB] FAIL rv_valid0: got %b expected 0", ifValid); end
            nChecks++; if (ifInstr !== BUBBLE) begin nFails++; $display("[TB] FAIL rv_bubble: got %h expected %h", ifInstr, BUBBLE); end
            nChecks++; if (imemReq !== 1'b1) begin nFails++; $display("[TB] FAIL rv_req: got %b expected 1", imemReq); end
            nChecks++; if (imemAddr !== 32'h2C) begin nFails++; $display("[TB] FAIL rv_addr: got %h expected 0000002c", imemAddr); end
            @(negedge clk);
            #1;
            nChecks++; if (ifValid !== 1'b0) begin nFails++; $display("[TB] FAIL rv_valid_wait: got %b expected 0", ifValid); end
            @(negedge clk);
            #1;
            nChecks++; if (ifValid !== 1'b1) begin nFails++; $display("[TB] FAIL rv_valid1: got %b expected 1", ifValid); end
            nChecks++; if (ifPc !== 32'h2C) begin nFails++; $display("[TB] FAIL rv_pc: got %h expected 0000002c", ifPc); end
            nChecks++; if (ifInstr !== memWord(32'h2C)) begin nFails++; $display("[TB] FAIL rv_instr: got %h expected %h", ifInstr, memWord(32'h2C)); end
        end
    endtask

    // Redirect to the last word of the address space; the PC wraps to 0.
    task automatic test_wrap;
        logic [31:0] got[$];
        int          idx;
        doReset();
        repeat (2) @(negedge clk);
        #1;
        redirectValid = 1'b1;
        redirectPc    = 32'hFFFF_FFFC;
        idx           = reqLog.size();
        @(negedge clk);
        #1;
        redirectValid = 1'b0;
        for (int i = 0; i < 30 && got.size() < 2; i++) begin
            if (ifValid && idReady) begin
                got.push_back(ifPc);
                nChecks++; if (ifInstr !== memWord(ifPc)) begin nFails++; $display("[TB] FAIL wrap_instr: got %h expected %h", ifInstr, memWord(ifPc)); end
            end
            @(negedge clk);
            #1;
        end
        nChecks++;
        if (got.size() < 2) begin nFails++; $display("[TB] FAIL wrap_count: got %0d instructions expected 2", got.size()); end
        else begin
            if (got[0] !== 32'hFFFF_FFFC) begin nFails++; $display("[TB] FAIL wrap_pc0: got %h expected fffffffc", got[0]); end
            nChecks++;
            if (got[1] !== 32'h0) begin nFails++; $display("[TB] FAIL wrap_pc1: got %h expected 00000000", got[1]); end
        end
        nChecks++;
        if (reqLog.size() < idx + 2) begin nFails++; $display("[TB] FAIL wrap_reqs: got %0d requests expected 2", reqLog.size() - idx); end
        else if (reqLog[idx] !== 32'hFFFF_FFFC || reqLog[idx+1] !== 32'h0) begin
            nFails++; $display("[TB] FAIL wrap_reqs: got %h,%h expected fffffffc,00000000", reqLog[idx], reqLog[idx+1]);
        end
    endtask

    // Reset pulse while a read is outstanding, with the late response
    // delivered during the IDLE cycle that follows. Memory is driven by hand.
    task automatic test_reset_mid_wait;
        doReset();
        autoMem    = 1'b0;
        imemRvalid = 1'b0;
        @(negedge clk); #1;
        nChecks++; if (imemReq !== 1'b1 || imemAddr !== RESET_PC) begin nFails++; $display("[TB] FAIL rmw_first_req: got %b/%h expected 1/%h", imemReq, imemAddr, RESET_PC); end
        @(negedge clk); #1;
        imemRvalid = 1'b1;
        imemRdata  = memWord(32'h0);
        @(negedge clk); #1;
        imemRvalid = 1'b0;
        idReady    = 1'b0;
        nChecks++; if (ifValid !== 1'b1 || ifPc !== 32'h0) begin nFails++; $display("[TB] FAIL rmw_pre_valid: got %b/%h expected 1/00000000", ifValid, ifPc); end
        @(negedge clk); #1;
        rstN = 1'b0;
        @(negedge clk); #1;
        nChecks++; if (ifValid !== 1'b0) begin nFails++; $display("[TB] FAIL rmw_valid: got %b expected 0", ifValid); end
        nChecks++; if (ifInstr !== BUBBLE) begin nFails++; $display("[TB] FAIL rmw_instr: got %h expected %h", ifInstr, BUBBLE); end
        nChecks++; if (ifPc !== 32'h0) begin nFails++; $display("[TB] FAIL rmw_pc: got %h expected 00000000", ifPc); end
        nChecks++; if (imemReq !== 1'b0) begin nFails++; $display("[TB] FAIL rmw_idle_req: got %b expected 0", imemReq); end
        rstN       = 1'b1;
        idReady    = 1'b1;
        imemRvalid = 1'b1;
        imemRdata  = 32'hDEAD_BEEF;
        @(negedge clk); #1;
        imemRvalid = 1'b0;
        nChecks++; if (imemReq !== 1'b1 || imemAddr !== RESET_PC) begin nFails++; $display("[TB] FAIL rmw_req: got %b/%h expected 1/%h", imemReq, imemAddr, RESET_PC); end
        nChecks++; if (ifValid !== 1'b0) begin nFails++; $display("[TB] FAIL rmw_late_ignored: got %b expected 0", ifValid); end
        @(negedge clk); #1;
        imemRvalid = 1'b1;
        imemRdata  = memWord(32'h0);
        @(negedge clk); #1;
        imemRvalid = 1'b0;
        nChecks++; if (ifValid !== 1'b1 || ifPc !== 32'h0 || ifInstr !== memWord(32'h0)) begin
            nFails++; $display("[TB] FAIL rmw_fetch: got %b/%h/%h expected 1/00000000/%h", ifValid, ifPc, ifInstr, memWord(32'h0));
        end
    endtask

    // Random decode readiness, memory latency and redirects. Whatever decode
    // accepts must follow program order: sequential PCs by 4 from reset, and
    // from the aligned target after each redirect.
    task automatic test_random;
        logic [31:0] expNext   = RESET_PC;
        int          consumed  = 0;
        bit          prevStall = 1'b0;
        logic [31:0] prevPc    = 32'h0;
        logic [31:0] prevInstr = 32'h0;
        doReset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (prevStall) begin
                nChecks++;
                if (ifValid !== 1'b1 || ifPc !== prevPc || ifInstr !== prevInstr) begin
                    nFails++; $display("[TB] FAIL rnd_stall_hold i%0d: got %b/%h/%h expected 1/%h/%h", i, ifValid, ifPc, ifInstr, prevPc, prevInstr);
                end
            end
            if (!ifValid) begin
                nChecks++; if (ifInstr !== BUBBLE) begin nFails++; $display("[TB] FAIL rnd_bubble i%0d: got %h expected %h", i, ifInstr, BUBBLE); end
            end
            idReady       = ($urandom_range(0, 3) != 0);
            redirectValid = ($urandom_range(0, 39) == 0);
            latency       = $urandom_range(1, 4);
            if (redirectValid) begin
                case ($urandom_range(0, 2))
                    0:       redirectPc = $urandom;
                    1:       redirectPc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                    default: redirectPc = $urandom & 32'hFF;
                endcase
            end
            if (ifValid && idReady) begin
                nChecks++;
                if (ifPc !== expNext || ifInstr !== memWord(expNext)) begin
                    nFails++; $display("[TB] FAIL rnd_stream i%0d: got %h/%h expected %h/%h", i, ifPc, ifInstr, expNext, memWord(expNext));
                end
                expNext  = expNext + 32'd4;
                consumed = consumed + 1;
            end
            if (redirectValid) expNext = redirectPc & ~32'h3;
            prevStall = ifValid && !idReady && !redirectValid;
            prevPc    = ifPc;
            prevInstr = ifInstr;
        end
        redirectValid = 1'b0;
        nChecks++; if (consumed < 150) begin nFails++; $display("[TB] FAIL rnd_progress: got %0d instructions expected at least 150", consumed); end
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        rstN          = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = 32'h0;
        idReady       = 1'b1;
        memKey        = $urandom;
        $display("[TB] starting if_fetch_unit bench, memory key %h", memKey);
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_stale();
        test_redirect_rvalid();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
